arm_multicycle_ctrl: RTL and testbench
======================================

# arm_multicycle_ctrl

Multicycle control unit for the ARM datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and holds the NZCV flag register. It gates all architectural writes with the condition-field check. It sits between the instruction register (Op/Funct/Rd/Cond fields), the ALU flag outputs, and the shared-memory multicycle datapath muxes and enables.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- Op  in  2  instr[27:26]: 00 data-processing, 01 memory, 10 branch
- Funct  in  6  instr[25:20]: [5] I, [4:1] cmd, [0] S; for memory, [0] L (load)
- Rd  in  4  instr[15:12]
- Cond  in  4  instr[31:28]
- ALUFlags  in  4  {N,Z,C,V} from ALU, valid in EXECR/EXECI
- PCWrite  out  1  PC register enable
- IRWrite  out  1  instruction register enable
- RegWrite  out  1  register file write enable
- MemWrite  out  1  memory write enable
- AdrSrc  out  1  0=PC, 1=ALUOut to memory address
- ALUSrcA  out  1  0=RD1, 1=PC
- ALUSrcB  out  2  00=WD2, 01=ExtImm, 10=const 4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- LinkW  out  1  selects R14 as write register (branch-with-link)
- Flags  out  4  current {N,Z,C,V} register
- State  out  4  current state encoding (debug)

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Encodings 10-15 are illegal and go to FETCH on the next edge.
- Transitions:
  - FETCH→DECODE.
  - DECODE: Op=01→MEMADR; Op=00 with I=0→EXECR, I=1→EXECI; Op=10→BRANCH; Op=11→FETCH (no-op).
  - MEMADR: L=1→MEMRD, L=0→MEMWR.
  - MEMRD→MEMWB→FETCH.
  - MEMWR→FETCH.
  - EXECR/EXECI: cmd=1010 (CMP)→FETCH, otherwise ALUWB.
  - ALUWB→FETCH. BRANCH→FETCH.
- Moore outputs per state (unlisted outputs are 0):
  - FETCH: IRWrite, PCWrite, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=00.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8 path).
  - MEMADR: ALUSrcB=01, ALUControl=00.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite gated.
  - MEMWR: AdrSrc=1, MemWrite gated.
  - EXECR: ALUSrcB=00. EXECI: ALUSrcB=01. Both drive ALUControl from cmd.
  - ALUWB: ResultSrc=00, RegWrite gated; if Rd=15, PCWrite gated instead of RegWrite.
  - BRANCH: ALUSrcB=01, ResultSrc=10, PCWrite gated.
- ALUControl decode from cmd: 0100→00, 0010→01, 1010→01, 0000→10, 1100→11. Any other cmd gives ALUControl=00, RegWrite stays 0 in ALUWB, and flags are not written.
- CondEx is combinational from Cond and the Flags register, using the standard ARM table for EQ..AL. Cond=1111 gives CondEx=0, never X.
- "Gated" means ANDed with CondEx.
- Flag write happens at the end of EXECR/EXECI when S=1 (CMP always) and CondEx=1:
  - ADD/SUB/CMP write all NZCV.
  - AND/ORR write N,Z only; C,V are held.

## Timing
- After reset: State=FETCH (0) and Flags=0000. While reset=1, PCWrite, IRWrite, RegWrite and MemWrite are forced 0. The other outputs show FETCH decode.
- Reset asserted in any state: State=FETCH on the next edge. No write enable is asserted in that cycle, and a partially executed instruction is abandoned.
- Cycles per instruction, FETCH to next FETCH:
  - LDR 5
  - STR 4
  - DP 4
  - CMP 3
  - B 3
  - undefined Op 2
- A flag write in EXECx is visible to the CondEx of the next instruction only; the same instruction's ALUWB uses the pre-update CondEx latched at EXECx exit. CondEx is registered on EXECx exit for use in ALUWB.
- FETCH PCWrite is unconditional (PC+4); only BRANCH/ALUWB-to-PC writes are gated.

## Configuration
- ARM_MC_BL_EN defined:
  - In BRANCH with Funct[4]=1 (L bit), assert RegWrite and LinkW, both gated, with ResultSrc held at 10 in that cycle.
  - The datapath writes PC-held value (PC+4) to R14; the PC update happens in the same cycle.
  - CPI is unchanged (3).
- Undefined: LinkW is tied 0, Funct[4] is ignored in BRANCH, and BL behaves as B.

## Test plan
- Reset held 2 cycles mid-MEMRD → State=0, Flags=0000, no RegWrite pulse, and FETCH IRWrite=1 on the first cycle after release.
- LDR (Op=01, L=1, Cond=1110) → states 0,1,2,3,4; RegWrite=1 only in state 4, with ResultSrc=01 there.
- SUBS (Op=00, I=1, cmd=0010, S=1) with ALUFlags=0110 → Flags=0110 after EXECI; ALUWB RegWrite=1; total 4 cycles.
- CMP, then BEQ with Z=1 → CMP takes 3 cycles with no RegWrite; BRANCH PCWrite=1. Repeat with Z=0 → BRANCH PCWrite=0.
- ADD with Cond=0000 (EQ), Flags=0000 → passes EXECR and ALUWB, RegWrite=0, Flags unchanged. Same instruction with Cond=1111 → RegWrite=0.
- BL (Funct[4]=1, Cond=1110) → with ARM_MC_BL_EN, BRANCH shows RegWrite=1, LinkW=1, PCWrite=1; without it, LinkW=0 and RegWrite=0.

Source files
------------

// File: rtl/arm_multicycle_ctrl.sv
// arm_multicycle_ctrl
//
// Multicycle control unit for the ARM datapath. It steps each instruction
// through FETCH / DECODE / MEM* / EXEC* / ALUWB / BRANCH, holds the NZCV
// flag register, and gates every architectural write with the condition
// check (CondEx).
//
// Optional feature macro: ARM_MC_BL_EN
//   defined   : BRANCH with Funct[4]=1 also writes the link register
//               (RegWrite and LinkW, both gated by CondEx).
//   undefined : LinkW is tied 0, so BL behaves as B.
//
// Handshake: there is none. The block is a pure Moore sequencer; instruction
// fields are expected stable from FETCH to the next FETCH, and ALUFlags is
// sampled only at the end of EXECR/EXECI.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   Op, Funct, Rd, Cond  instruction register fields
//   ALUFlags             {N,Z,C,V} from the ALU (valid in EXECR/EXECI)
//   PCWrite, IRWrite,    write enables (all forced 0 while reset=1)
//   RegWrite, MemWrite
//   AdrSrc, ALUSrcA,     datapath mux selects
//   ALUSrcB, ResultSrc
//   ALUControl           00 ADD, 01 SUB, 10 AND, 11 ORR
//   LinkW                selects R14 as the write register (BL)
//   Flags                current {N,Z,C,V}
//   State                current state encoding (debug)

module arm_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic       LinkW,
    output logic [3:0] Flags,
    output logic [3:0] State
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [3:0] out_state;
    logic [3:0] flags;
    logic       condex;
    logic       condex_q;

    logic [3:0] cmd;
    logic       ibit;
    logic       sbit;
    logic       lbit;
    logic       is_cmp;
    logic       cmd_ok;
    logic       logic_op;
    logic [1:0] alu_ctl;
    logic       in_exec;
    logic       flag_we;

    assign cmd    = Funct[4:1];
    assign ibit   = Funct[5];
    assign sbit   = Funct[0];
    assign lbit   = Funct[0];
    assign is_cmp = (cmd == 4'b1010);

    // Command decode. Unsupported commands fall back to ADD on the ALU but
    // are marked invalid so they never write a register, the PC or flags.
    always_comb begin
        alu_ctl  = 2'b00;
        cmd_ok   = 1'b1;
        logic_op = 1'b0;
        case (cmd)
            4'b0100: alu_ctl = 2'b00;
            4'b0010: alu_ctl = 2'b01;
            4'b1010: alu_ctl = 2'b01;
            4'b0000: begin
                alu_ctl  = 2'b10;
                logic_op = 1'b1;
            end
            4'b1100: begin
                alu_ctl  = 2'b11;
                logic_op = 1'b1;
            end
            default: cmd_ok = 1'b0;
        endcase
    end

    // Condition check against the flag register (not the live ALU flags).
    always_comb begin
        case (Cond)
            4'b0000: condex = flags[2];
            4'b0001: condex = ~flags[2];
            4'b0010: condex = flags[1];
            4'b0011: condex = ~flags[1];
            4'b0100: condex = flags[3];
            4'b0101: condex = ~flags[3];
            4'b0110: condex = flags[0];
            4'b0111: condex = ~flags[0];
            4'b1000: condex = flags[1] & ~flags[2];
            4'b1001: condex = ~flags[1] | flags[2];
            4'b1010: condex = (flags[3] == flags[0]);
            4'b1011: condex = (flags[3] != flags[0]);
            4'b1100: condex = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: condex = flags[2] | (flags[3] != flags[0]);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_nxt = ibit ? S_EXECI : S_EXECR;
                    2'b01:   state_nxt = S_MEMADR;
                    2'b10:   state_nxt = S_BRANCH;
                    default: state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: state_nxt = lbit ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_nxt = S_MEMWB;
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWR:  state_nxt = S_FETCH;
            S_EXECR,
            S_EXECI:  state_nxt = is_cmp ? S_FETCH : S_ALUWB;
            S_ALUWB:  state_nxt = S_FETCH;
            S_BRANCH: state_nxt = S_FETCH;
            default:  state_nxt = S_FETCH;
        endcase
    end

    assign in_exec = (state == S_EXECR) || (state == S_EXECI);
    assign flag_we = in_exec && cmd_ok && condex && (sbit || is_cmp);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            flags    <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            state <= state_nxt;
            // ALUWB must see the condition as it was before this
            // instruction's own flag update, so capture it on EXECx exit.
            if (in_exec) begin
                condex_q <= condex;
            end
            if (flag_we) begin
                if (logic_op) begin
                    flags <= {ALUFlags[3:2], flags[1:0]};
                end else begin
                    flags <= ALUFlags;
                end
            end
        end
    end

    // While reset is held the outputs show the FETCH decode regardless of
    // where the state register currently is.
    assign out_state = reset ? S_FETCH : state;

    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        LinkW      = 1'b0;
        case (out_state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = condex;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = condex;
            end
            S_EXECR: begin
                ALUSrcB    = 2'b00;
                ALUControl = alu_ctl;
            end
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_ctl;
            end
            S_ALUWB: begin
                ResultSrc = 2'b00;
                if (cmd_ok) begin
                    if (Rd == 4'd15) begin
                        PCWrite = condex_q;
                    end else begin
                        RegWrite = condex_q;
                    end
                end
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = condex;
`ifdef ARM_MC_BL_EN
                if (Funct[4]) begin
                    RegWrite = condex;
                    LinkW    = condex;
                end
`endif
            end
            default: ;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            LinkW    = 1'b0;
        end
    end

    assign Flags = flags;
    assign State = state;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
module tb_arm_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic       PCWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ALUControl;
  logic       LinkW;
  logic [3:0] Flags;
  logic [3:0] State;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] m_flags;

  arm_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .LinkW(LinkW), .Flags(Flags), .State(State)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ARM condition: even codes test a base predicate, odd codes invert it.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  function automatic logic [4:0] wen_now();
    return {PCWrite, IRWrite, RegWrite, MemWrite, LinkW};
  endfunction

  // Execute one instruction from FETCH to the next FETCH, checking every
  // cycle against the reference sequence derived from the instruction class.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] rd, input logic [3:0] cond,
                           input logic [3:0] aflags);
    logic [3:0] seq[$];
    logic [4:0] wen[$];
    logic       pass;
    logic [3:0] cmd;
    logic       ok;
    logic       lgc;
    logic [1:0] actl;
    logic [3:0] new_flags;
    logic [4:0] last_we;
    cmd  = funct[4:1];
    pass = cond_ok(cond, m_flags);
    ok = 1'b1; lgc = 1'b0; actl = 2'd0;
    case (cmd)
      4'd4:  actl = 2'd0;
      4'd2:  actl = 2'd1;
      4'd10: actl = 2'd1;
      4'd0:  begin actl = 2'd2; lgc = 1'b1; end
      4'd12: begin actl = 2'd3; lgc = 1'b1; end
      default: ok = 1'b0;
    endcase
    new_flags = m_flags;
    last_we   = 5'b00000;
    seq = '{4'd0, 4'd1};
    case (op)
      2'b01: begin
        if (funct[0]) begin
          seq.push_back(4'd2); seq.push_back(4'd3); seq.push_back(4'd4);
          last_we = {2'b00, pass, 2'b00};
        end else begin
          seq.push_back(4'd2); seq.push_back(4'd5);
          last_we = {3'b000, pass, 1'b0};
        end
      end
      2'b00: begin
        seq.push_back(funct[5] ? 4'd7 : 4'd6);
        if (cmd != 4'd10) begin
          seq.push_back(4'd8);
          if (ok) last_we = (rd == 4'd15) ? {pass, 4'b0000} : {2'b00, pass, 2'b00};
        end
        if (ok && pass && (funct[0] || cmd == 4'd10))
          new_flags = lgc ? {aflags[3:2], m_flags[1:0]} : aflags;
      end
      2'b10: begin
        seq.push_back(4'd9);
        last_we = {pass, 4'b0000};
`ifdef ARM_MC_BL_EN
        if (funct[4]) last_we = {pass, 1'b0, pass, 1'b0, pass};
`endif
      end
      default: ;
    endcase
    for (int i = 0; i < seq.size(); i++) wen.push_back(5'b00000);
    wen[0] = 5'b11000;
    if (seq.size() > 2 && !(op == 2'b00 && cmd == 4'd10)) wen[seq.size()-1] = last_we;

    Op = op; Funct = funct; Rd = rd; Cond = cond; ALUFlags = aflags;
    for (int i = 0; i < seq.size(); i++) begin
      @(negedge clk);
      check("state", {4'd0, State}, {4'd0, seq[i]});
      check("wen", {3'd0, wen_now()}, {3'd0, wen[i]});
      if (seq[i] == 4'd6 || seq[i] == 4'd7) check("aluctl", {6'd0, ALUControl}, {6'd0, actl});
      if (seq[i] == 4'd4) check("memwb_resultsrc", {6'd0, ResultSrc}, 8'h01);
      if (seq[i] == 4'd0) check("fetch_resultsrc", {6'd0, ResultSrc}, 8'h02);
      @(posedge clk);
      #1;
    end
    m_flags = new_flags;
    check("flags", {4'd0, Flags}, {4'd0, m_flags});
    check("back_to_fetch", {4'd0, State}, 8'h00);
  endtask

  initial begin
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd, cond;
    logic [3:0] valid_cmds[5];
    valid_cmds = '{4'd4, 4'd2, 4'd10, 4'd0, 4'd12};
    reset = 1'b1; Op = 2'b11; Funct = 6'd0; Rd = 4'd0; Cond = 4'hE; ALUFlags = 4'd0;
    m_flags = 4'd0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", {4'd0, State}, 8'h00);
    check("rst_flags", {4'd0, Flags}, 8'h00);
    check("rst_wen", {3'd0, wen_now()}, 8'h00);
    check("rst_alusrcb", {6'd0, ALUSrcB}, 8'h02);
    check("rst_alusrca", {7'd0, ALUSrcA}, 8'h01);
    @(posedge clk);
    #1 reset = 1'b0;

    // ADD EQ with Z=0: fails; S=1 but flags must stay 0000
    run_instr(2'b00, {1'b0, 4'b0100, 1'b1}, 4'd3, 4'b0000, 4'b1111);
    check("addeq_flags", {4'd0, Flags}, 8'h00);
    // same with Cond=1111
    run_instr(2'b00, {1'b0, 4'b0100, 1'b1}, 4'd3, 4'b1111, 4'b1111);
    // LDR
    run_instr(2'b01, 6'b000001, 4'd2, 4'hE, 4'd0);
    // STR
    run_instr(2'b01, 6'b000000, 4'd2, 4'hE, 4'd0);
    // SUBS immediate
    run_instr(2'b00, {1'b1, 4'b0010, 1'b1}, 4'd1, 4'hE, 4'b0110);
    check("subs_flags", {4'd0, Flags}, 8'h06);
    // CMP giving Z=1, then BEQ taken
    run_instr(2'b00, {1'b0, 4'b1010, 1'b0}, 4'd0, 4'hE, 4'b0100);
    run_instr(2'b10, 6'b000000, 4'd0, 4'b0000, 4'd0);
    // CMP giving Z=0, then BEQ not taken
    run_instr(2'b00, {1'b0, 4'b1010, 1'b0}, 4'd0, 4'hE, 4'b1001);
    run_instr(2'b10, 6'b000000, 4'd0, 4'b0000, 4'd0);
    // BL
    run_instr(2'b10, 6'b010000, 4'd0, 4'hE, 4'd0);
    // ORRS: only N,Z updated
    run_instr(2'b00, {1'b0, 4'b1100, 1'b1}, 4'd5, 4'hE, 4'b0110);
    // ADD to PC
    run_instr(2'b00, {1'b0, 4'b0100, 1'b0}, 4'd15, 4'hE, 4'd0);
    // undefined op
    run_instr(2'b11, 6'd0, 4'd0, 4'hE, 4'd0);

    // reset held 2 cycles mid-MEMRD
    Op = 2'b01; Funct = 6'b000001; Cond = 4'hE;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_memrd", {4'd0, State}, 8'h03);
    reset = 1'b1;
    @(negedge clk);
    check("rst_memrd_wen", {3'd0, wen_now()}, 8'h00);
    @(posedge clk);
    #1;
    check("rst_memrd_state", {4'd0, State}, 8'h00);
    @(negedge clk);
    check("rst_hold_wen", {3'd0, wen_now()}, 8'h00);
    @(posedge clk);
    #1 reset = 1'b0;
    m_flags = 4'd0;
    check("rst_memrd_flags", {4'd0, Flags}, 8'h00);
    @(negedge clk);
    check("post_rst_irwrite", {7'd0, IRWrite}, 8'h01);
    check("post_rst_state", {4'd0, State}, 8'h00);
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_ldr_done", {4'd0, State}, 8'h00);

    // random instructions
    for (int k = 0; k < 80; k++) begin
      op = 2'($urandom_range(0, 3));
      funct = 6'($urandom);
      if (op == 2'b00 && $urandom_range(0, 4) != 0)
        funct[4:1] = valid_cmds[$urandom_range(0, 4)];
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      cond = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom);
      run_instr(op, funct, rd, cond, 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
